bht_update_ctrl: RTL

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: 2-bit BHT counter table with a queued read-modify-write updater.
// Optional macro BHT_CTRL_FWD_EN forwards a same-cycle WR value to lookups.
module bht_update_ctrl #(
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic              busy,
  output logic              mem_csb0,
  output logic              mem_web0,
  output logic [ADDR_W-1:0] mem_addr0,
  input  logic [1:0]        mem_dout0,
  output logic              mem_csb1,
  output logic              mem_web1,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [1:0]        mem_din1,
  input  logic [1:0]        mem_dout1
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] init_idx;
  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic              q_tkn  [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_tkn;
  logic [1:0]        sat_nx;
  logic              look_busy;
  logic [1:0]        ctr;
  logic              unused_ctr;

  assign busy      = (state == INIT);
  assign upd_ready = ~rst & (count < CW'(QDEPTH));
  assign push      = upd_valid & upd_ready;

  assign mem_csb0  = rst | ~fetch_valid;
  assign mem_web0  = 1'b1;
  assign mem_addr0 = fetch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (init_idx == '1) state_nx = IDLE;
      IDLE: if (count != '0) state_nx = RD;
      RD:   state_nx = WR;
      WR:   state_nx = (count != '0) ? RD : IDLE;
    endcase
  end

  always_comb begin
    sat_nx = mem_dout1;
    if (wb_tkn) begin
      if (mem_dout1 != 2'b11) sat_nx = mem_dout1 + 2'b01;
    end else if (mem_dout1 != 2'b00) begin
      sat_nx = mem_dout1 - 2'b01;
    end
  end

  always_comb begin
    mem_csb1  = 1'b1;
    mem_web1  = 1'b1;
    mem_addr1 = '0;
    mem_din1  = 2'b00;
    pop       = 1'b0;
    unique case (state)
      INIT: begin
        mem_csb1  = 1'b0;
        mem_web1  = 1'b0;
        mem_addr1 = init_idx;
        mem_din1  = 2'b01;
      end
      IDLE: ;
      RD: begin
        mem_csb1  = 1'b0;
        mem_addr1 = q_addr[rd_ptr];
        pop       = 1'b1;
      end
      WR: begin
        mem_csb1  = 1'b0;
        mem_web1  = 1'b0;
        mem_addr1 = wb_addr;
        mem_din1  = sat_nx;
      end
    endcase
    // the SRAM must stay deselected while reset is held
    if (rst) begin
      mem_csb1 = 1'b1;
      pop      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wb_addr  <= '0;
      wb_tkn   <= 1'b0;
    end else begin
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wb_addr <= q_addr[rd_ptr];
        wb_tkn  <= q_tkn[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= upd_addr;
      q_tkn[wr_ptr]  <= upd_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      look_busy  <= 1'b1;
    end else begin
      pred_valid <= fetch_valid;
      look_busy  <= busy;
    end
  end

`ifdef BHT_CTRL_FWD_EN
  logic       fwd_hit;
  logic [1:0] fwd_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit <= 1'b0;
      fwd_val <= 2'b00;
    end else begin
      fwd_hit <= fetch_valid && (state == WR) && (wb_addr == fetch_addr);
      fwd_val <= sat_nx;
    end
  end

  assign ctr = fwd_hit ? fwd_val : mem_dout0;
`else
  assign ctr = mem_dout0;
`endif

  assign pred_taken = pred_valid & ~look_busy & ctr[1];
  assign unused_ctr = ctr[0];
endmodule
